// File: rtl/sample_iter_ctrl_pkg.sv
// Shared constants and FSM state type for the sample iteration stage.
package sample_iter_ctrl_pkg;

   localparam int unsigned SIGFIG = 24;
   localparam int unsigned RADIX  = 10;
   localparam int unsigned VERTS  = 3;
   localparam int unsigned AXIS   = 3;
   localparam int unsigned COLORS = 3;
   localparam int unsigned SAMPS  = 4;

   // Step is one pixel (2**RADIX) shifted right by these amounts per MSAA mode
   localparam int unsigned SHIFT_MSAA1  = 0;
   localparam int unsigned SHIFT_MSAA4  = 1;
   localparam int unsigned SHIFT_MSAA16 = 2;
   localparam int unsigned SHIFT_MSAA64 = 3;

   typedef enum logic {
      WAIT = 1'b0,
      TEST = 1'b1
   } state_e;

endpackage

// File: rtl/sample_step_dec.sv
// One-hot subsample select to sample step and low-bit clearing mask.
module sample_step_dec #(
   parameter int unsigned SIGFIG = sample_iter_ctrl_pkg::SIGFIG,
   parameter int unsigned RADIX  = sample_iter_ctrl_pkg::RADIX
) (
   input  logic [3:0]        subSample_i,
   output logic [SIGFIG-1:0] step_o,
   output logic [SIGFIG-1:0] mask_o
);
   import sample_iter_ctrl_pkg::*;

   // Highest set bit wins; an empty select falls back to one sample per pixel
   always_comb begin
      step_o = SIGFIG'(1) << (RADIX - SHIFT_MSAA1);
      if (subSample_i[3])      step_o = SIGFIG'(1) << (RADIX - SHIFT_MSAA1);
      else if (subSample_i[2]) step_o = SIGFIG'(1) << (RADIX - SHIFT_MSAA4);
      else if (subSample_i[1]) step_o = SIGFIG'(1) << (RADIX - SHIFT_MSAA16);
      else if (subSample_i[0]) step_o = SIGFIG'(1) << (RADIX - SHIFT_MSAA64);
      mask_o = ~(step_o - SIGFIG'(1));
   end

endmodule

// File: rtl/sample_iter_ctrl.sv
// Walks a triangle's bounding box on the sample grid, SAMPS samples per cycle.
module sample_iter_ctrl #(
   parameter int unsigned SIGFIG = sample_iter_ctrl_pkg::SIGFIG,
   parameter int unsigned RADIX  = sample_iter_ctrl_pkg::RADIX,
   parameter int unsigned VERTS  = sample_iter_ctrl_pkg::VERTS,
   parameter int unsigned AXIS   = sample_iter_ctrl_pkg::AXIS,
   parameter int unsigned COLORS = sample_iter_ctrl_pkg::COLORS,
   parameter int unsigned SAMPS  = sample_iter_ctrl_pkg::SAMPS
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
   input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
   input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
   input  logic                                  validTri_R13H,
   input  logic [3:0]                            subSample_RnnnnU,
   output logic                                  halt_RnnnnL,
   output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
   output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
   output logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S,
   output logic [SAMPS-1:0]                      validSamp_R14H
);
   import sample_iter_ctrl_pkg::*;

   state_e                                state_q, state_d;
   logic [SIGFIG-1:0]                     step_q, step_d, dec_step, dec_mask;
   logic signed [SIGFIG-1:0]              llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
   logic signed [SIGFIG-1:0]              cx_q, cx_d, cy_q, cy_d, span;
   logic                                  halt_q, halt_d;
   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
   logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
   logic [1:0][SAMPS-1:0][SIGFIG-1:0]      samp_q, samp_d;
   logic [SAMPS-1:0]                      valid_q, valid_d;
   logic                                  emit;

   sample_step_dec #(
      .SIGFIG(SIGFIG),
      .RADIX (RADIX)
   ) u_step_dec (
      .subSample_i(subSample_RnnnnU),
      .step_o     (dec_step),
      .mask_o     (dec_mask)
   );

   assign span = $signed(SIGFIG'(SAMPS) * step_q);

   // Cursor names the group being presented; outputs are loaded from the next cursor
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      llx_d   = llx_q;
      urx_d   = urx_q;
      ury_d   = ury_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      tri_d   = tri_q;
      color_d = color_q;
      samp_d  = samp_q;
      valid_d = '0;
      emit    = 1'b0;

      unique case (state_q)
         WAIT: begin
            if (validTri_R13H) begin
               state_d = TEST;
               step_d  = dec_step;
               llx_d   = $signed(box_R13S[0][0] & dec_mask);
               cy_d    = $signed(box_R13S[0][1] & dec_mask);
               urx_d   = $signed(box_R13S[1][0] & dec_mask);
               ury_d   = $signed(box_R13S[1][1] & dec_mask);
               cx_d    = llx_d;
               tri_d   = tri_R13S;
               color_d = color_R13U;
               emit    = 1'b1;
            end
         end
         TEST: begin
            if (cx_q + span <= urx_q) begin
               cx_d = cx_q + span;
               emit = 1'b1;
            end else begin
               cx_d = llx_q;
               cy_d = cy_q + $signed(step_q);
               if (cy_d > ury_q) state_d = WAIT;
               else              emit    = 1'b1;
            end
         end
         default: state_d = WAIT;
      endcase

      if (emit) begin
         for (int j = 0; j < int'(SAMPS); j++) begin
            samp_d[0][j] = cx_d + $signed(SIGFIG'(j) * step_d);
            samp_d[1][j] = cy_d;
            valid_d[j]   = $signed(samp_d[0][j]) <= urx_d;
         end
      end

      halt_d = (state_d == WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT;
         step_q  <= '0;
         llx_q   <= '0;
         urx_q   <= '0;
         ury_q   <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         halt_q  <= 1'b1;
         tri_q   <= '0;
         color_q <= '0;
         samp_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         llx_q   <= llx_d;
         urx_q   <= urx_d;
         ury_q   <= ury_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         halt_q  <= halt_d;
         tri_q   <= tri_d;
         color_q <= color_d;
         samp_q  <= samp_d;
         valid_q <= valid_d;
      end
   end

   assign halt_RnnnnL    = halt_q;
   assign tri_R14S       = tri_q;
   assign color_R14U     = color_q;
   assign sample_R14S    = samp_q;
   assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Self-checking bench for sample_iter_ctrl: directed table, random boxes vs a
// row/column enumeration model, and asynchronous reset sequences.
module tb_sample_iter_ctrl;
   import sample_iter_ctrl_pkg::*;

   localparam int NS = 4;

   logic                                  clk, rst;
   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S, tri_R14S;
   logic [COLORS-1:0][SIGFIG-1:0]          color_R13U, color_R14U;
   logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
   logic                                  validTri_R13H;
   logic [3:0]                            subSample_RnnnnU;
   logic                                  halt_RnnnnL;
   logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S;
   logic [SAMPS-1:0]                      validSamp_R14H;

   sample_iter_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .tri_R13S        (tri_R13S),
      .color_R13U      (color_R13U),
      .box_R13S        (box_R13S),
      .validTri_R13H   (validTri_R13H),
      .subSample_RnnnnU(subSample_RnnnnU),
      .halt_RnnnnL     (halt_RnnnnL),
      .tri_R14S        (tri_R14S),
      .color_R14U      (color_R14U),
      .sample_R14S     (sample_R14S),
      .validSamp_R14H  (validSamp_R14H)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NS-1:0][31:0] x;
      logic [NS-1:0][31:0] y;
      logic [NS-1:0]       v;
   } grp_t;

   typedef struct {
      logic [3:0] sub;
      int         llx, lly, urx, ury;
      int         n;
      logic [3:0] v_first, v_last;
      int         x_last, y_last;
   } vec_t;

   grp_t exp_q[$];
   grp_t obs_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check_eq(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int step_of(input logic [3:0] s);
      if (s[3]) return 1024;
      if (s[2]) return 512;
      if (s[1]) return 256;
      return 128;
   endfunction

   function automatic int floor_to(input int v, input int s);
      int r;
      r = v % s;
      if (r < 0) r += s;
      return v - r;
   endfunction

   // Reference: enumerate grid rows, then groups of NS samples along each row
   function automatic void build_model(input logic [3:0] sub, input int llx, input int lly,
                                       input int urx, input int ury);
      int   s, lx, ly, ux, uy;
      grp_t g;
      s  = step_of(sub);
      lx = floor_to(llx, s);
      ly = floor_to(lly, s);
      ux = floor_to(urx, s);
      uy = floor_to(ury, s);
      exp_q.delete();
      for (int y = ly; y <= uy; y += s) begin
         for (int x = lx; x <= ux; x += NS * s) begin
            for (int j = 0; j < NS; j++) begin
               g.x[j] = 32'(x + j * s);
               g.y[j] = 32'(y);
               g.v[j] = (x + j * s <= ux);
            end
            exp_q.push_back(g);
         end
      end
   endfunction

   // Issue one triangle, collect every group until ready returns, compare with model.
   // While busy, the inputs are scrambled and validTri pulsed; none of it may stick.
   task automatic run_tri(input logic [3:0] sub, input int llx, input int lly,
                          input int urx, input int ury);
      logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_v;
      logic [COLORS-1:0][SIGFIG-1:0]          color_v;
      grp_t g;
      int   n;
      build_model(sub, llx, lly, urx, ury);
      for (int v = 0; v < int'(VERTS); v++)
         for (int a = 0; a < int'(AXIS); a++) tri_v[v][a] = SIGFIG'($urandom);
      for (int c = 0; c < int'(COLORS); c++) color_v[c] = SIGFIG'($urandom);

      check_eq("ready_before_capture", int'(halt_RnnnnL), 1);
      tri_R13S         = tri_v;
      color_R13U       = color_v;
      subSample_RnnnnU = sub;
      box_R13S[0][0]   = SIGFIG'(llx);
      box_R13S[0][1]   = SIGFIG'(lly);
      box_R13S[1][0]   = SIGFIG'(urx);
      box_R13S[1][1]   = SIGFIG'(ury);
      validTri_R13H    = 1'b1;
      @(posedge clk); #1;
      validTri_R13H = 1'b0;
      obs_q.delete();

      for (int c = 0; c < 400 && !halt_RnnnnL; c++) begin
         for (int j = 0; j < NS; j++) begin
            g.x[j] = 32'($signed(sample_R14S[0][j]));
            g.y[j] = 32'($signed(sample_R14S[1][j]));
         end
         g.v = validSamp_R14H;
         obs_q.push_back(g);
         subSample_RnnnnU = 4'b0001 << $urandom_range(3);
         validTri_R13H    = ($urandom_range(2) == 0);
         if (validTri_R13H) begin
            tri_R13S[0][0] = SIGFIG'($urandom);
            tri_R13S[2][1] = SIGFIG'($urandom);
            box_R13S[0][0] = SIGFIG'($urandom_range(4096));
            box_R13S[1][1] = SIGFIG'($urandom_range(8192));
         end
         @(posedge clk); #1;
      end
      validTri_R13H = 1'b0;

      check_eq("halt_after_last", int'(halt_RnnnnL), 1);
      check_eq("valid_idle", int'(validSamp_R14H), 0);
      check_eq("group_count", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i] != exp_q[i]) begin
            errors++;
            $display("FAIL group[%0d]: got x=%0d,%0d,%0d,%0d y=%0d,%0d v=%b expected x=%0d,%0d,%0d,%0d y=%0d,%0d v=%b",
                     i, $signed(obs_q[i].x[0]), $signed(obs_q[i].x[1]), $signed(obs_q[i].x[2]),
                     $signed(obs_q[i].x[3]), $signed(obs_q[i].y[0]), $signed(obs_q[i].y[3]), obs_q[i].v,
                     $signed(exp_q[i].x[0]), $signed(exp_q[i].x[1]), $signed(exp_q[i].x[2]),
                     $signed(exp_q[i].x[3]), $signed(exp_q[i].y[0]), $signed(exp_q[i].y[3]), exp_q[i].v);
         end
      end
      check_eq("tri_hold", int'(tri_R14S == tri_v), 1);
      check_eq("color_hold", int'(color_R14U == color_v), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl [6];
      logic [3:0] sub;
      int         s, llx, lly, urx, ury;

      tbl[0] = '{4'b1000, 0, 0, 3072, 1024, 2, 4'b1111, 4'b1111, 0, 1024};
      tbl[1] = '{4'b0100, 0, 0, 1024, 0, 1, 4'b0111, 4'b0111, 0, 0};
      tbl[2] = '{4'b1000, 2048, 2048, 2048, 2048, 1, 4'b0001, 4'b0001, 2048, 2048};
      tbl[3] = '{4'b1000, 1500, 700, 3000, 1100, 2, 4'b0011, 4'b0011, 1024, 1024};
      tbl[4] = '{4'b0001, 0, 0, 640, 128, 4, 4'b1111, 4'b0011, 512, 128};
      tbl[5] = '{4'b0010, -300, -10, 100, 0, 2, 4'b0111, 4'b0111, -512, 0};

      rst              = 1'b0;
      validTri_R13H    = 1'b0;
      tri_R13S         = '0;
      color_R13U       = '0;
      box_R13S         = '0;
      subSample_RnnnnU = 4'b1000;

      // Reset takes effect before any clock edge
      #2 rst = 1'b1;
      #1;
      check_eq("rst_halt", int'(halt_RnnnnL), 1);
      check_eq("rst_valid", int'(validSamp_R14H), 0);
      check_eq("rst_tri_zero", int'(tri_R14S == '0), 1);
      check_eq("rst_color_zero", int'(color_R14U == '0), 1);
      check_eq("rst_sample_zero", int'(sample_R14S == '0), 1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_after_rst", int'(halt_RnnnnL), 1);

      // Directed table, issued back to back
      for (int i = 0; i < 6; i++) begin
         run_tri(tbl[i].sub, tbl[i].llx, tbl[i].lly, tbl[i].urx, tbl[i].ury);
         check_eq($sformatf("tbl%0d_groups", i), obs_q.size(), tbl[i].n);
         if (obs_q.size() > 0) begin
            check_eq($sformatf("tbl%0d_v_first", i), int'(obs_q[0].v), int'(tbl[i].v_first));
            check_eq($sformatf("tbl%0d_v_last", i), int'(obs_q[$].v), int'(tbl[i].v_last));
            check_eq($sformatf("tbl%0d_x_last", i), int'($signed(obs_q[$].x[0])), tbl[i].x_last);
            check_eq($sformatf("tbl%0d_y_last", i), int'($signed(obs_q[$].y[0])), tbl[i].y_last);
         end
      end

      // Random boxes, including negative coordinates and unaligned corners
      for (int t = 0; t < 30; t++) begin
         sub = 4'b0001 << $urandom_range(3);
         s   = step_of(sub);
         llx = int'($urandom_range(8192)) - 4096;
         lly = int'($urandom_range(8192)) - 4096;
         urx = llx + int'($urandom_range(8 * s));
         ury = lly + int'($urandom_range(4 * s));
         run_tri(sub, llx, lly, urx, ury);
      end

      // Reset in the middle of a long row
      subSample_RnnnnU = 4'b0001;
      box_R13S[0][0]   = '0;
      box_R13S[0][1]   = '0;
      box_R13S[1][0]   = SIGFIG'(5120);
      box_R13S[1][1]   = SIGFIG'(1280);
      validTri_R13H    = 1'b1;
      @(posedge clk); #1;
      validTri_R13H = 1'b0;
      @(posedge clk); #1;
      check_eq("busy_before_rst", int'(halt_RnnnnL), 0);
      check_eq("valid_before_rst", int'(validSamp_R14H), 15);
      check_eq("x0_before_rst", int'($signed(sample_R14S[0][0])), 512);
      #2 rst = 1'b1;
      #1;
      check_eq("midrst_halt", int'(halt_RnnnnL), 1);
      check_eq("midrst_valid", int'(validSamp_R14H), 0);
      check_eq("midrst_tri_zero", int'(tri_R14S == '0), 1);
      check_eq("midrst_sample_zero", int'(sample_R14S == '0), 1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check_eq($sformatf("no_residual_valid%0d", c), int'(validSamp_R14H), 0);
         check_eq($sformatf("no_residual_halt%0d", c), int'(halt_RnnnnL), 1);
      end

      // Recovery after reset
      run_tri(tbl[0].sub, tbl[0].llx, tbl[0].lly, tbl[0].urx, tbl[0].ury);
      check_eq("recover_groups", obs_q.size(), tbl[0].n);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
